// File: rtl/ikun_pkg.sv
// Shared types and helpers for the dual-stream alignment front end.
package ikun_pkg;

  localparam int PIX_W = 24;

  // Number of bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

  // One aligned pixel pair as it travels through the skid buffer.
  typedef struct packed {
    logic [PIX_W-1:0] data0;
    logic [PIX_W-1:0] data1;
    logic             user;
    logic             last;
  } axis_pair_t;

  localparam int PAIR_W = $bits(axis_pair_t);

  typedef enum logic {
    ST_SEEK = 1'b0,
    ST_RUN  = 1'b1
  } align_state_t;

endpackage

// File: rtl/ikun_axis_skid.sv
// Two-entry registered skid buffer. in_ready is a flop, so downstream ready
// never reaches upstream ready combinationally.
module ikun_axis_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] out_data_nxt;
  logic [WIDTH-1:0] skid_data_nxt;
  logic             skid_valid;
  logic             out_valid_nxt;
  logic             skid_valid_nxt;
  logic             push;
  logic             pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next contents: drain the output slot first, refill it from the skid entry,
  // then park a new beat wherever there is room (output slot preferred).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (pop) begin
      if (skid_valid) begin
        out_data_nxt   = skid_data;
        skid_valid_nxt = 1'b0;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end
    if (push) begin
      if (!out_valid_nxt) begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = in_data;
      end else begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = in_data;
      end
    end
  end

  // Occupancy flags and the registered ready; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= out_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
    end
  end

  // Payload registers.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; the valid flags alone decide whether it means anything.
    out_data  <= out_data_nxt;
    skid_data <= skid_data_nxt;
  end

endmodule

// File: rtl/ikun_dual_stream_align.sv
// Aligns the live camera stream (s0) with the previous-frame read-back (s1):
// drops beats until both sit on SOF, then releases pixel pairs in lockstep,
// re-seeking on any geometry or SOF error.
module ikun_dual_stream_align
  import ikun_pkg::*;
#(
  parameter int VIDEO_WIDTH  = 1280,
  parameter int VIDEO_HEIGHT = 720
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] s0_axis_tdata,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic             s0_axis_tuser,
  input  logic             s0_axis_tlast,
  input  logic [PIX_W-1:0] s1_axis_tdata,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  input  logic             s1_axis_tuser,
  input  logic             s1_axis_tlast,
  output logic [PIX_W-1:0] m0_axis_tdata,
  output logic             m0_axis_tvalid,
  input  logic             m0_axis_tready,
  output logic             m0_axis_tuser,
  output logic             m0_axis_tlast,
  output logic [PIX_W-1:0] m1_axis_tdata,
  output logic             m1_axis_tvalid,
  input  logic             m1_axis_tready,
  output logic             m1_axis_tuser,
  output logic             m1_axis_tlast,
  output logic             aligned,
  output logic             frame_done,
  output logic [7:0]       resync_cnt
);

  localparam int COL_W = clog2(VIDEO_WIDTH);
  localparam int ROW_W = clog2(VIDEO_HEIGHT);

  align_state_t     state;
  align_state_t     state_nxt;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             live;
  logic             col_last;
  logic             row_last;
  logic             at_origin;
  logic             sof0;
  logic             sof1;
  logic             candidate;
  logic             accept;
  logic             err;
  logic             buf_ready;
  logic             buf_valid;
  axis_pair_t       buf_in;
  axis_pair_t       buf_out;

  assign col_last  = (col_cnt == COL_W'(VIDEO_WIDTH - 1));
  assign row_last  = (row_cnt == ROW_W'(VIDEO_HEIGHT - 1));
  assign at_origin = (col_cnt == '0) && (row_cnt == '0);
  assign sof0      = s0_axis_tvalid & s0_axis_tuser;
  assign sof1      = s1_axis_tvalid & s1_axis_tuser;
  assign candidate = s0_axis_tvalid & s1_axis_tvalid & buf_ready;
  assign aligned   = (state == ST_RUN);

  // Next state, input readies and error/accept qualification.
  always_comb begin
    state_nxt      = state;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    err            = 1'b0;
    accept         = 1'b0;
    frame_done     = 1'b0;
    case (state)
      ST_SEEK: begin
        // Junk is swallowed; an SOF beat is held until its partner shows up.
        s0_axis_tready = live & !sof0;
        s1_axis_tready = live & !sof1;
        if (live && sof0 && sof1) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        err = candidate &
              (((s0_axis_tuser | s1_axis_tuser) & !at_origin) |
               (s0_axis_tlast != s1_axis_tlast) |
               (s0_axis_tlast != col_last));
        accept         = candidate & !err;
        // Each side is only taken together with the other, never alone.
        s0_axis_tready = s1_axis_tvalid & buf_ready & !err;
        s1_axis_tready = s0_axis_tvalid & buf_ready & !err;
        if (err) begin
          state_nxt = ST_SEEK;
        end else if (accept && col_last && row_last) begin
          frame_done = 1'b1;
          state_nxt  = ST_SEEK;
        end
      end
      default: state_nxt = ST_SEEK;
    endcase
  end

  // State register plus the flag that keeps readies low right out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SEEK;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // Raster position of the next expected pixel pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (err || (accept && col_last && row_last)) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Saturating count of error-triggered resynchronisations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resync_cnt <= '0;
    end else if (err && (resync_cnt != 8'hFF)) begin
      resync_cnt <= resync_cnt + 1'b1;
    end
  end

  assign buf_in.data0 = s0_axis_tdata;
  assign buf_in.data1 = s1_axis_tdata;
  assign buf_in.user  = at_origin;
  assign buf_in.last  = col_last;

  ikun_axis_skid #(
    .WIDTH(PAIR_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (buf_in),
    .in_valid (accept),
    .in_ready (buf_ready),
    .out_data (buf_out),
    .out_valid(buf_valid),
    .out_ready(m0_axis_tready & m1_axis_tready)
  );

  assign m0_axis_tdata  = buf_out.data0;
  assign m1_axis_tdata  = buf_out.data1;
  assign m0_axis_tvalid = buf_valid;
  assign m1_axis_tvalid = buf_valid;
  assign m0_axis_tuser  = buf_out.user;
  assign m1_axis_tuser  = buf_out.user;
  assign m0_axis_tlast  = buf_out.last;
  assign m1_axis_tlast  = buf_out.last;

endmodule

// File: tb/tb_ikun_dual_stream_align.sv
// Self-checking bench for ikun_dual_stream_align on an 8x4 frame.
module tb_ikun_dual_stream_align;
  import ikun_pkg::*;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s0_tdata = '0, s1_tdata = '0;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic        s0_tuser = 1'b0, s1_tuser = 1'b0;
  logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic        s0_tready, s1_tready;
  logic [23:0] m0_tdata, m1_tdata;
  logic        m0_tvalid, m1_tvalid, m0_tuser, m1_tuser, m0_tlast, m1_tlast;
  logic        m0_tready = 1'b1, m1_tready = 1'b1;
  logic        aligned, frame_done;
  logic [7:0]  resync_cnt;

  always #5 clk = ~clk;

  ikun_dual_stream_align #(
    .VIDEO_WIDTH (W),
    .VIDEO_HEIGHT(H)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s0_axis_tdata (s0_tdata),
    .s0_axis_tvalid(s0_tvalid),
    .s0_axis_tready(s0_tready),
    .s0_axis_tuser (s0_tuser),
    .s0_axis_tlast (s0_tlast),
    .s1_axis_tdata (s1_tdata),
    .s1_axis_tvalid(s1_tvalid),
    .s1_axis_tready(s1_tready),
    .s1_axis_tuser (s1_tuser),
    .s1_axis_tlast (s1_tlast),
    .m0_axis_tdata (m0_tdata),
    .m0_axis_tvalid(m0_tvalid),
    .m0_axis_tready(m0_tready),
    .m0_axis_tuser (m0_tuser),
    .m0_axis_tlast (m0_tlast),
    .m1_axis_tdata (m1_tdata),
    .m1_axis_tvalid(m1_tvalid),
    .m1_axis_tready(m1_tready),
    .m1_axis_tuser (m1_tuser),
    .m1_axis_tlast (m1_tlast),
    .aligned       (aligned),
    .frame_done    (frame_done),
    .resync_cnt    (resync_cnt)
  );

  int          tests = 0;
  int          failed = 0;
  beat_t       q0[$], q1[$];
  logic [49:0] got[$], exp_q[$];
  int          out_cyc[$], acc_cyc[$];
  int          idx0, idx1, dly0, dly1;
  bit          f0_last, f1_last, gap_en, rand_ready, stall_prev;
  logic [50:0] held;
  int          cyc = 0, hold0, fd_cnt, exp_frames, exp_resync = 0;
  logic [7:0]  prev_resync = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_frame(input int which);
    beat_t b;
    for (int k = 0; k < NPIX; k++) begin
      b.data = 24'($urandom);
      b.user = (k == 0);
      b.last = ((k % W) == W - 1);
      if (which == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic add_junk(input int which, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = 24'($urandom);
      b.user = 1'b0;
      b.last = 1'($urandom_range(0, 1));
      if (which == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic start_test();
    q0.delete(); q1.delete(); got.delete(); exp_q.delete();
    out_cyc.delete(); acc_cyc.delete();
    idx0 = 0; idx1 = 0; dly0 = 0; dly1 = 0;
    f0_last = 0; f1_last = 0;
    hold0 = 0; fd_cnt = 0; exp_frames = 0;
  endtask

  // Present the next beat of each source; a beat stays up until it is taken.
  task automatic drive_sources();
    if (f0_last) begin idx0++; dly0 = gap_en ? int'($urandom_range(0, 2)) : 0; end
    if (f1_last) begin idx1++; dly1 = gap_en ? int'($urandom_range(0, 2)) : 0; end
    if (dly0 > 0) begin dly0--; s0_tvalid = 1'b0; end
    else if (idx0 < q0.size()) begin
      s0_tvalid = 1'b1; s0_tdata = q0[idx0].data; s0_tuser = q0[idx0].user; s0_tlast = q0[idx0].last;
    end else s0_tvalid = 1'b0;
    if (dly1 > 0) begin dly1--; s1_tvalid = 1'b0; end
    else if (idx1 < q1.size()) begin
      s1_tvalid = 1'b1; s1_tdata = q1[idx1].data; s1_tuser = q1[idx1].user; s1_tlast = q1[idx1].last;
    end else s1_tvalid = 1'b0;
  endtask

  // One clock: drive after the rising edge, observe on the falling edge.
  task automatic step();
    logic f0, f1, mf;
    @(posedge clk); #1;
    drive_sources();
    m0_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    m1_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    cyc++;
    f0 = s0_tvalid & s0_tready;
    f1 = s1_tvalid & s1_tready;
    mf = m0_tvalid & m0_tready & m1_tready;
    if (m0_tvalid | m1_tvalid)
      check("mirror", 64'({m1_tvalid, m1_tuser, m1_tlast}), 64'({m0_tvalid, m0_tuser, m0_tlast}));
    if (stall_prev)
      check("stable", 64'({m0_tvalid, m0_tdata, m1_tdata, m0_tuser, m0_tlast}), 64'(held));
    stall_prev = m0_tvalid & !mf;
    held = {1'b1, m0_tdata, m1_tdata, m0_tuser, m0_tlast};
    if (mf) begin
      got.push_back({m0_tdata, m1_tdata, m0_tuser, m0_tlast});
      out_cyc.push_back(cyc);
    end
    if (aligned & (f0 | f1)) begin
      check("lockstep", 64'(f0), 64'(f1));
      if (f0 & f1) acc_cyc.push_back(cyc);
    end
    if (s0_tvalid & s0_tuser & !s0_tready) hold0++;
    if (frame_done) fd_cnt++;
    if (resync_cnt != prev_resync) begin
      check("unaligned_on_err", 64'(aligned), 64'(0));
      prev_resync = resync_cnt;
    end
    f0_last = f0;
    f1_last = f1;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (idx0 >= q0.size()) && (idx1 >= q1.size()) && !m0_tvalid && !m1_tvalid;
    end
    check({tag, "_drained"}, 64'(done), 64'(1));
    repeat (3) step();
  endtask

  // Reference: walk both beat lists frame by frame, pairing by raster index.
  task automatic build_expected();
    int i0, i1;
    bit stop, col_end, bad;
    i0 = 0; i1 = 0; stop = 0;
    exp_q.delete();
    while (!stop) begin
      while (i0 < q0.size() && !q0[i0].user) i0++;
      while (i1 < q1.size() && !q1[i1].user) i1++;
      if (i0 >= q0.size() || i1 >= q1.size()) break;
      for (int k = 0; k < NPIX; k++) begin
        if (i0 >= q0.size() || i1 >= q1.size()) begin stop = 1; break; end
        col_end = ((k % W) == W - 1);
        bad = ((k != 0) && (q0[i0].user || q1[i1].user)) ||
              (q0[i0].last != q1[i1].last) || (q0[i0].last != col_end);
        if (bad) begin
          exp_resync = (exp_resync < 255) ? exp_resync + 1 : 255;
          if (k == 0) stop = 1;
          break;
        end
        exp_q.push_back({q0[i0].data, q1[i1].data, (k == 0), col_end});
        i0++;
        i1++;
        if (k == NPIX - 1) exp_frames++;
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    build_expected();
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      check({tag, "_pair"}, 64'(got[k]), 64'(exp_q[k]));
    check({tag, "_frames"}, 64'(fd_cnt), 64'(exp_frames));
    check({tag, "_resync"}, 64'(resync_cnt), 64'(exp_resync));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset_outs", 64'({m0_tvalid, m1_tvalid, s0_tready, s1_tready, aligned, frame_done}), 64'(0));
    check("reset_resync", 64'(resync_cnt), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    gap_en = 0; rand_ready = 0; stall_prev = 0;
    start_test();
    repeat (3) step();

    // 1: both SOFs together, readies high
    start_test();
    add_frame(0); add_frame(1);
    run_until_idle("t1", 200);
    compare_outputs("t1");
    check("t1_pairs", 64'(out_cyc.size()), 64'(NPIX));
    for (int k = 0; k < got.size(); k++)
      check("t1_flags", 64'(got[k][1:0]), 64'({(k == 0), ((k % W) == W - 1)}));
    for (int k = 0; k < out_cyc.size() && k < acc_cyc.size(); k++)
      check("t1_latency", 64'(out_cyc[k]), 64'(acc_cyc[k] + 1));
    if (out_cyc.size() == NPIX)
      check("t1_throughput", 64'(out_cyc[NPIX-1] - out_cyc[0]), 64'(NPIX - 1));

    // 2: s1 SOF five cycles late; s0 waits 5 cycles plus the cycle that detects the pair
    start_test();
    add_frame(0); add_frame(1);
    dly1 = 5;
    run_until_idle("t2", 200);
    compare_outputs("t2");
    check("t2_s0_hold", 64'(hold0), 64'(6));

    // 3: three junk beats ahead of s0 SOF
    start_test();
    add_junk(0, 3); add_frame(0); add_frame(1);
    run_until_idle("t3", 200);
    compare_outputs("t3");
    check("t3_first_pix", 64'((got.size() > 0) ? got[0][49:26] : 24'h0), 64'(q0[3].data));

    // 4: stray s1 tlast on the 14th beat (col 5, row 1), then a clean frame
    start_test();
    add_frame(0); add_frame(1);
    q1[13].last = 1'b1;
    add_frame(0); add_frame(1);
    run_until_idle("t4", 300);
    compare_outputs("t4");
    check("t4_total", 64'(got.size()), 64'(13 + NPIX));
    check("t4_resync", 64'(resync_cnt), 64'(1));

    // 5: random readies and source gaps over junk and two frames
    start_test();
    gap_en = 1; rand_ready = 1;
    add_junk(0, int'($urandom_range(0, 4))); add_junk(1, int'($urandom_range(0, 4)));
    add_frame(0); add_frame(1);
    add_junk(1, 2);
    add_frame(0); add_frame(1);
    run_until_idle("t5", 1500);
    compare_outputs("t5");
    gap_en = 0; rand_ready = 0;

    // 6: reset mid-frame discards everything, then a fresh frame aligns
    start_test();
    add_frame(0); add_frame(1);
    repeat (12) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_outs", 64'({m0_tvalid, m1_tvalid, s0_tready, s1_tready, aligned}), 64'(0));
    check("t6_rst_resync", 64'(resync_cnt), 64'(0));
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_resync = resync_cnt;
    exp_resync = 0;
    stall_prev = 0;
    start_test();
    repeat (2) step();
    start_test();
    add_frame(0); add_frame(1);
    run_until_idle("t6", 200);
    compare_outputs("t6");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
